// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - pool of grid bullets with fire allocation, movement, expiry, kill and VGA overlay
module bullet_pool #(
    parameter int          NUM_BUL   = 4,
    parameter int          POS_W     = 5,
    parameter int          X_MAX     = 19,
    parameter int          Y_MAX     = 14,
    parameter int          CELL_PX   = 32,
    parameter int          BUL_PX    = 8,
    parameter int          COOLDOWN  = 2,
    parameter logic [11:0] BUL_COLOR = 12'hFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       move_tick,
    input  logic                       fire_req,
    input  logic [1:0]                 fire_dir,
    input  logic [POS_W-1:0]           fire_x,
    input  logic [POS_W-1:0]           fire_y,
    output logic                       fire_ack,
    output logic                       fire_nack,
    input  logic [NUM_BUL-1:0]         hit_clr,
    output logic [NUM_BUL-1:0]         bul_active,
    output logic [NUM_BUL*POS_W-1:0]   bul_x,
    output logic [NUM_BUL*POS_W-1:0]   bul_y,
    output logic [NUM_BUL*2-1:0]       bul_dir,
    output logic [NUM_BUL-1:0]         expired,
    input  logic [10:0]                VGA_xpos,
    input  logic [10:0]                VGA_ypos,
    output logic [11:0]                VGA_data,
    output logic                       VGA_en
);

    localparam int CELL_SH = $clog2(CELL_PX);
    localparam int OFF     = (CELL_PX - BUL_PX) / 2;
    localparam int CD_W    = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    logic [NUM_BUL-1:0] active;
    logic [POS_W-1:0]   pos_x [NUM_BUL];
    logic [POS_W-1:0]   pos_y [NUM_BUL];
    logic [1:0]         pos_d [NUM_BUL];
    logic [NUM_BUL-1:0] expired_q;
    logic [CD_W-1:0]    cooldown;
    logic               ack_q;
    logic               nack_q;
    logic               owned;
    logic               vga_en_q;

    logic               free_found;
    logic [NUM_BUL-1:0] load_sel;
    logic               in_grid;
    logic               accept;

    // True when one more step in direction d from (x, y) would leave the grid
    function automatic logic leaves_grid(input logic [POS_W-1:0] x,
                                         input logic [POS_W-1:0] y,
                                         input logic [1:0]       d);
        case (d)
            DIR_UP:    leaves_grid = (y == '0);
            DIR_DOWN:  leaves_grid = (y == POS_W'(Y_MAX));
            DIR_LEFT:  leaves_grid = (x == '0);
            default:   leaves_grid = (x == POS_W'(X_MAX));
        endcase
    endfunction

    // True when scan coordinate p falls within the bullet square of cell c on one axis
    function automatic logic in_span(input logic [POS_W-1:0] c, input logic [10:0] p);
        logic [10:0] lo;
        lo      = (11'(c) << CELL_SH) + 11'(OFF);
        in_span = (p >= lo) && (p < lo + 11'(BUL_PX));
    endfunction

    // Lowest-index free slot, from registered flags so a freed slot is reusable next cycle only
    always_comb begin
        free_found = 1'b0;
        load_sel   = '0;
        for (int i = 0; i < NUM_BUL; i++) begin
            if (!active[i] && !free_found) begin
                free_found  = 1'b1;
                load_sel[i] = 1'b1;
            end
        end
    end

    assign in_grid = (fire_x <= POS_W'(X_MAX)) && (fire_y <= POS_W'(Y_MAX));
    assign accept  = fire_req && free_found && (cooldown == '0) && in_grid;

    // Per-slot state: kill beats movement, movement beats a fresh load
    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= '0;
            expired_q <= '0;
            for (int i = 0; i < NUM_BUL; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                pos_d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BUL; i++) begin
                expired_q[i] <= 1'b0;
                if (hit_clr[i] && active[i]) begin
                    active[i] <= 1'b0;
                end else if (move_tick && active[i]) begin
                    if (leaves_grid(pos_x[i], pos_y[i], pos_d[i])) begin
                        active[i]    <= 1'b0;
                        expired_q[i] <= 1'b1;
                    end else begin
                        case (pos_d[i])
                            DIR_UP:    pos_y[i] <= pos_y[i] - POS_W'(1);
                            DIR_DOWN:  pos_y[i] <= pos_y[i] + POS_W'(1);
                            DIR_LEFT:  pos_x[i] <= pos_x[i] - POS_W'(1);
                            default:   pos_x[i] <= pos_x[i] + POS_W'(1);
                        endcase
                    end
                end else if (accept && load_sel[i]) begin
                    active[i] <= 1'b1;
                    pos_x[i]  <= fire_x;
                    pos_y[i]  <= fire_y;
                    pos_d[i]  <= fire_dir;
                end
            end
        end
    end

    // Fire rate limit: reload on accept, otherwise count down on move ticks to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cooldown <= '0;
        end else if (accept) begin
            cooldown <= CD_W'(COOLDOWN);
        end else if (move_tick && (cooldown != '0)) begin
            cooldown <= cooldown - CD_W'(1);
        end
    end

    // One ack or nack pulse per sampled request
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
        end else begin
            ack_q  <= accept;
            nack_q <= fire_req && !accept;
        end
    end

    // Pixel ownership test across all active slots
    always_comb begin
        owned = 1'b0;
        for (int i = 0; i < NUM_BUL; i++) begin
            if (active[i] && in_span(pos_x[i], VGA_xpos) && in_span(pos_y[i], VGA_ypos)) begin
                owned = 1'b1;
            end
        end
    end

    // Register the overlay result for a fixed one-cycle render latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_en_q <= 1'b0;
        end else begin
            vga_en_q <= owned;
        end
    end

    assign VGA_en     = vga_en_q;
    assign VGA_data   = vga_en_q ? BUL_COLOR : 12'h000;
    assign fire_ack   = ack_q;
    assign fire_nack  = nack_q;
    assign bul_active = active;
    assign expired    = expired_q;

    for (genvar g = 0; g < NUM_BUL; g++) begin : g_pack
        assign bul_x[g*POS_W +: POS_W] = pos_x[g];
        assign bul_y[g*POS_W +: POS_W] = pos_y[g];
        assign bul_dir[g*2 +: 2]       = pos_d[g];
    end

endmodule

// File: tb/tb_bullet_pool.sv
// tb/tb_bullet_pool.sv - directed self-checking bench for bullet_pool
module tb_bullet_pool;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_tick;
    logic        fire_req;
    logic [1:0]  fire_dir;
    logic [4:0]  fire_x;
    logic [4:0]  fire_y;
    logic        fire_ack;
    logic        fire_nack;
    logic [3:0]  hit_clr;
    logic [3:0]  bul_active;
    logic [19:0] bul_x;
    logic [19:0] bul_y;
    logic [7:0]  bul_dir;
    logic [3:0]  expired;
    logic [10:0] VGA_xpos;
    logic [10:0] VGA_ypos;
    logic [11:0] VGA_data;
    logic        VGA_en;

    int checks = 0;
    int errors = 0;

    bullet_pool dut (
        .clk(clk), .rst(rst), .move_tick(move_tick),
        .fire_req(fire_req), .fire_dir(fire_dir), .fire_x(fire_x), .fire_y(fire_y),
        .fire_ack(fire_ack), .fire_nack(fire_nack), .hit_clr(hit_clr),
        .bul_active(bul_active), .bul_x(bul_x), .bul_y(bul_y), .bul_dir(bul_dir),
        .expired(expired), .VGA_xpos(VGA_xpos), .VGA_ypos(VGA_ypos),
        .VGA_data(VGA_data), .VGA_en(VGA_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; move_tick = 1'b0; fire_req = 1'b0; fire_dir = 2'b00;
        fire_x = '0; fire_y = '0; hit_clr = '0; VGA_xpos = '0; VGA_ypos = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic fire(input logic [1:0] d, input logic [4:0] x, input logic [4:0] y);
        fire_req = 1'b1; fire_dir = d; fire_x = x; fire_y = y;
        step();
        fire_req = 1'b0;
    endtask

    task automatic move();
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; move_tick = 1'b1; fire_req = 1'b1; fire_dir = 2'b11;
        fire_x = 5'd1; fire_y = 5'd1; hit_clr = '0; VGA_xpos = 11'd44; VGA_ypos = 11'd44;
        step(); step();
        checks++;
        if (bul_active !== 4'h0 || expired !== 4'h0) begin
            errors++; $display("FAIL reset_flags active=%h expired=%h want 0 0", bul_active, expired);
        end
        checks++;
        if (fire_ack !== 1'b0 || fire_nack !== 1'b0) begin
            errors++; $display("FAIL reset_handshake ack=%b nack=%b want 0 0", fire_ack, fire_nack);
        end
        checks++;
        if (VGA_en !== 1'b0 || VGA_data !== 12'h000 || bul_x !== 20'h0 || bul_y !== 20'h0) begin
            errors++; $display("FAIL reset_outputs en=%b data=%h x=%h y=%h want all 0", VGA_en, VGA_data, bul_x, bul_y);
        end
    endtask

    task automatic test_fire_move();
        do_reset();
        fire(2'b11, 5'd3, 5'd5);
        checks++;
        if (fire_ack !== 1'b1 || fire_nack !== 1'b0 || bul_active !== 4'h1) begin
            errors++; $display("FAIL first_fire ack=%b nack=%b active=%h want 1 0 1", fire_ack, fire_nack, bul_active);
        end
        checks++;
        if (bul_x[4:0] !== 5'd3 || bul_y[4:0] !== 5'd5 || bul_dir[1:0] !== 2'b11) begin
            errors++; $display("FAIL first_pos x=%0d y=%0d d=%0d want 3 5 3", bul_x[4:0], bul_y[4:0], bul_dir[1:0]);
        end
        step();
        checks++;
        if (fire_ack !== 1'b0) begin
            errors++; $display("FAIL ack_pulse ack=%b want 0", fire_ack);
        end
        move(); move(); move();
        checks++;
        if (bul_x[4:0] !== 5'd6 || bul_y[4:0] !== 5'd5 || bul_active !== 4'h1) begin
            errors++; $display("FAIL three_moves x=%0d y=%0d active=%h want 6 5 1", bul_x[4:0], bul_y[4:0], bul_active);
        end
    endtask

    task automatic test_fill();
        logic [3:0] want;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            fire(2'b11, 5'd0, 5'(k));
            want = 4'((1 << (k + 1)) - 1);
            checks++;
            if (fire_ack !== 1'b1 || bul_active !== want) begin
                errors++; $display("FAIL fill_%0d ack=%b active=%h want 1 %h", k, fire_ack, bul_active, want);
            end
            move(); move();
        end
        checks++;
        if (bul_y[19:15] !== 5'd3 || bul_x[19:15] !== 5'd2) begin
            errors++; $display("FAIL fill_slot3 x=%0d y=%0d want 2 3", bul_x[19:15], bul_y[19:15]);
        end
        fire(2'b11, 5'd0, 5'd9);
        checks++;
        if (fire_nack !== 1'b1 || fire_ack !== 1'b0 || bul_active !== 4'hF) begin
            errors++; $display("FAIL pool_full nack=%b ack=%b active=%h want 1 0 f", fire_nack, fire_ack, bul_active);
        end
    endtask

    task automatic test_cooldown();
        do_reset();
        fire(2'b00, 5'd4, 5'd10);
        checks++;
        if (fire_ack !== 1'b1) begin
            errors++; $display("FAIL cd_first ack=%b want 1", fire_ack);
        end
        fire(2'b00, 5'd7, 5'd12);
        checks++;
        if (fire_nack !== 1'b1 || fire_ack !== 1'b0 || bul_active !== 4'h1) begin
            errors++; $display("FAIL cd_block nack=%b ack=%b active=%h want 1 0 1", fire_nack, fire_ack, bul_active);
        end
        move();
        fire(2'b00, 5'd7, 5'd12);
        checks++;
        if (fire_nack !== 1'b1) begin
            errors++; $display("FAIL cd_one_tick nack=%b want 1", fire_nack);
        end
        move();
        fire(2'b00, 5'd7, 5'd12);
        checks++;
        if (fire_ack !== 1'b1 || bul_active !== 4'h3 || bul_x[9:5] !== 5'd7 || bul_y[9:5] !== 5'd12) begin
            errors++; $display("FAIL cd_release ack=%b active=%h x1=%0d y1=%0d want 1 3 7 12", fire_ack, bul_active, bul_x[9:5], bul_y[9:5]);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        fire(2'b11, 5'd19, 5'd4);
        move();
        checks++;
        if (bul_active !== 4'h0 || expired !== 4'h1 || bul_x[4:0] !== 5'd19) begin
            errors++; $display("FAIL exit_right active=%h expired=%h x=%0d want 0 1 19", bul_active, expired, bul_x[4:0]);
        end
        step();
        checks++;
        if (expired !== 4'h0) begin
            errors++; $display("FAIL expired_pulse expired=%h want 0", expired);
        end
        do_reset();
        fire(2'b00, 5'd7, 5'd0);
        move();
        checks++;
        if (bul_active !== 4'h0 || expired !== 4'h1 || bul_y[4:0] !== 5'd0) begin
            errors++; $display("FAIL exit_up active=%h expired=%h y=%0d want 0 1 0", bul_active, expired, bul_y[4:0]);
        end
        do_reset();
        fire(2'b11, 5'd20, 5'd3);
        checks++;
        if (fire_nack !== 1'b1 || fire_ack !== 1'b0 || bul_active !== 4'h0) begin
            errors++; $display("FAIL spawn_x20 nack=%b ack=%b active=%h want 1 0 0", fire_nack, fire_ack, bul_active);
        end
        fire(2'b11, 5'd3, 5'd15);
        checks++;
        if (fire_nack !== 1'b1 || bul_active !== 4'h0) begin
            errors++; $display("FAIL spawn_y15 nack=%b active=%h want 1 0", fire_nack, bul_active);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        fire(2'b00, 5'd5, 5'd5);
        hit_clr = 4'h1; move_tick = 1'b1;
        step();
        hit_clr = 4'h0; move_tick = 1'b0;
        checks++;
        if (bul_active !== 4'h0 || expired !== 4'h0 || bul_y[4:0] !== 5'd5) begin
            errors++; $display("FAIL kill_vs_move active=%h expired=%h y=%0d want 0 0 5", bul_active, expired, bul_y[4:0]);
        end
        move();
        fire_req = 1'b1; fire_dir = 2'b01; fire_x = 5'd9; fire_y = 5'd2; move_tick = 1'b1;
        step();
        fire_req = 1'b0; move_tick = 1'b0;
        checks++;
        if (fire_ack !== 1'b1 || bul_active !== 4'h1 || bul_x[4:0] !== 5'd9 || bul_y[4:0] !== 5'd2) begin
            errors++; $display("FAIL fire_with_tick ack=%b active=%h x=%0d y=%0d want 1 1 9 2", fire_ack, bul_active, bul_x[4:0], bul_y[4:0]);
        end
        move();
        checks++;
        if (bul_y[4:0] !== 5'd3 || bul_x[4:0] !== 5'd9) begin
            errors++; $display("FAIL first_step x=%0d y=%0d want 9 3", bul_x[4:0], bul_y[4:0]);
        end
    endtask

    task automatic test_vga();
        do_reset();
        VGA_xpos = 11'd76; VGA_ypos = 11'd44;
        fire(2'b00, 5'd2, 5'd1);
        checks++;
        if (VGA_en !== 1'b0) begin
            errors++; $display("FAIL vga_not_yet en=%b want 0", VGA_en);
        end
        step();
        checks++;
        if (VGA_en !== 1'b1 || VGA_data !== 12'hFFF) begin
            errors++; $display("FAIL vga_76_44 en=%b data=%h want 1 fff", VGA_en, VGA_data);
        end
        VGA_xpos = 11'd75;
        step();
        checks++;
        if (VGA_en !== 1'b0 || VGA_data !== 12'h000) begin
            errors++; $display("FAIL vga_75_44 en=%b data=%h want 0 000", VGA_en, VGA_data);
        end
        VGA_xpos = 11'd84;
        step();
        checks++;
        if (VGA_en !== 1'b0) begin
            errors++; $display("FAIL vga_84_44 en=%b want 0", VGA_en);
        end
        VGA_xpos = 11'd83; VGA_ypos = 11'd51;
        step();
        checks++;
        if (VGA_en !== 1'b1 || VGA_data !== 12'hFFF) begin
            errors++; $display("FAIL vga_83_51 en=%b data=%h want 1 fff", VGA_en, VGA_data);
        end
        VGA_ypos = 11'd52;
        step();
        checks++;
        if (VGA_en !== 1'b0) begin
            errors++; $display("FAIL vga_83_52 en=%b want 0", VGA_en);
        end
    endtask

    initial begin
        test_reset();
        test_fire_move();
        test_fill();
        test_cooldown();
        test_boundary();
        test_simultaneous();
        test_vga();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
